// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops plus an optional
// shift-add unsigned multiplier compiled in when SEQ_ALU_MUL_EN is defined.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [4:0]       i_sel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_c,
    output logic             o_z,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDC = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SUBC = 5'd3;
    localparam logic [4:0] OP_CMP  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_EXOR = 5'd7;
    localparam logic [4:0] OP_TEST = 5'd8;
    localparam logic [4:0] OP_LSL  = 5'd9;
    localparam logic [4:0] OP_LSR  = 5'd10;
    localparam logic [4:0] OP_ROL  = 5'd11;
    localparam logic [4:0] OP_ROR  = 5'd12;
    localparam logic [4:0] OP_ASR  = 5'd13;
    localparam logic [4:0] OP_MOV  = 5'd14;
    localparam logic [4:0] OP_PASS = 5'd15;

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_result;
    logic               r_c;
    logic               r_z;
    logic               r_done;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_val;
    logic               w_c;
    logic               w_z;
    logic               w_wr_res;
    logic               w_wr_flags;
    logic               w_is_mul;

`ifdef SEQ_ALU_MUL_EN
    localparam logic [4:0] OP_MUL = 5'd16;
    localparam int         CW     = $clog2(WIDTH);

    logic [WIDTH-1:0]   r_result_hi;
    logic               r_busy;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_is_mul    = (i_sel == OP_MUL);
    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
    assign o_result_hi = r_result_hi;
    assign o_busy      = r_busy;
`else
    assign w_is_mul    = 1'b0;
    assign o_result_hi = {WIDTH{1'b0}};
    assign o_busy      = 1'b0;
`endif

    assign o_result = r_result;
    assign o_c      = r_c;
    assign o_z      = r_z;
    assign o_done   = r_done;
    assign w_z      = (w_val == {WIDTH{1'b0}});

    // Single-cycle datapath; C defaults to its held value so MOV/PASS keep it.
    always_comb begin
        w_sum      = {(WIDTH+1){1'b0}};
        w_val      = {WIDTH{1'b0}};
        w_c        = r_c;
        w_wr_res   = 1'b0;
        w_wr_flags = 1'b0;
        case (i_sel)
            OP_ADD, OP_ADDC: begin
                w_sum      = {1'b0, i_a} + {1'b0, i_b}
                           + {{WIDTH{1'b0}}, (i_sel == OP_ADDC) & i_cin};
                w_val      = w_sum[WIDTH-1:0];
                w_c        = w_sum[WIDTH];
                w_wr_res   = 1'b1;
                w_wr_flags = 1'b1;
            end
            OP_SUB, OP_SUBC, OP_CMP: begin
                // Borrow falls out as bit WIDTH of the widened difference.
                w_sum      = {1'b0, i_a} - {1'b0, i_b}
                           - {{WIDTH{1'b0}}, (i_sel == OP_SUBC) & i_cin};
                w_val      = w_sum[WIDTH-1:0];
                w_c        = w_sum[WIDTH];
                w_wr_res   = (i_sel != OP_CMP);
                w_wr_flags = 1'b1;
            end
            OP_AND, OP_TEST: begin
                w_val      = i_a & i_b;
                w_c        = 1'b0;
                w_wr_res   = (i_sel == OP_AND);
                w_wr_flags = 1'b1;
            end
            OP_OR: begin
                w_val      = i_a | i_b;
                w_c        = 1'b0;
                w_wr_res   = 1'b1;
                w_wr_flags = 1'b1;
            end
            OP_EXOR: begin
                w_val      = i_a ^ i_b;
                w_c        = 1'b0;
                w_wr_res   = 1'b1;
                w_wr_flags = 1'b1;
            end
            OP_LSL: begin
                {w_c, w_val} = {i_a, i_cin};
                w_wr_res     = 1'b1;
                w_wr_flags   = 1'b1;
            end
            OP_LSR: begin
                w_c        = i_a[0];
                w_val      = {i_cin, i_a[WIDTH-1:1]};
                w_wr_res   = 1'b1;
                w_wr_flags = 1'b1;
            end
            OP_ROL: begin
                w_c        = i_a[WIDTH-1];
                w_val      = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
                w_wr_res   = 1'b1;
                w_wr_flags = 1'b1;
            end
            OP_ROR: begin
                w_c        = i_a[0];
                w_val      = {i_a[0], i_a[WIDTH-1:1]};
                w_wr_res   = 1'b1;
                w_wr_flags = 1'b1;
            end
            OP_ASR: begin
                w_c        = i_a[0];
                w_val      = {i_a[WIDTH-1], i_a[WIDTH-1:1]};
                w_wr_res   = 1'b1;
                w_wr_flags = 1'b1;
            end
            OP_MOV: begin
                w_val      = i_b;
                w_wr_res   = 1'b1;
                w_wr_flags = 1'b1;
            end
            OP_PASS: begin
                w_val      = i_a;
                w_wr_res   = 1'b1;
                w_wr_flags = 1'b1;
            end
            default: begin
                w_val = {WIDTH{1'b0}};
            end
        endcase
    end

    // Control FSM and all output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_result    <= {WIDTH{1'b0}};
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_done      <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            r_result_hi <= {WIDTH{1'b0}};
            r_busy      <= 1'b0;
            r_cnt       <= {CW{1'b0}};
            r_mcand     <= {(2*WIDTH){1'b0}};
            r_mplier    <= {WIDTH{1'b0}};
            r_acc       <= {(2*WIDTH){1'b0}};
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && w_is_mul) begin
`ifdef SEQ_ALU_MUL_EN
                        r_state  <= S_MUL;
                        r_busy   <= 1'b1;
                        r_cnt    <= {CW{1'b0}};
                        r_mcand  <= {{WIDTH{1'b0}}, i_a};
                        r_mplier <= i_b;
                        r_acc    <= {(2*WIDTH){1'b0}};
`endif
                    end else if (i_start) begin
                        r_done <= 1'b1;
                        if (w_wr_res) begin
                            r_result    <= w_val;
`ifdef SEQ_ALU_MUL_EN
                            r_result_hi <= {WIDTH{1'b0}};
`endif
                        end
                        if (w_wr_flags) begin
                            r_c <= w_c;
                            r_z <= w_z;
                        end
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (r_cnt == CW'(WIDTH-1)) begin
                        r_result    <= w_acc_next[WIDTH-1:0];
                        r_result_hi <= w_acc_next[2*WIDTH-1:WIDTH];
                        r_c         <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_z         <= (w_acc_next == {(2*WIDTH){1'b0}});
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cnt       <= {CW{1'b0}};
                        r_state     <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8): directed vectors push expectations,
// a negedge monitor pops one entry per DONE pulse and compares.
module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [4:0]   sel;
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] result, result_hi;
    logic         c, z, busy, done;

    typedef struct {
        int           id;
        logic [W-1:0] r;
        logic [W-1:0] hi;
        logic         c;
        logic         z;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   vid   = 0;

    seq_alu #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_sel(sel),
        .i_a(a), .i_b(b), .i_cin(cin),
        .o_result(result), .o_result_hi(result_hi), .o_c(c), .o_z(z),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one START for a single cycle; optionally record its expected outcome.
    task automatic issue(input logic [4:0] s, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic [W-1:0] er, input logic [W-1:0] ehi,
                         input logic ec, input logic ez, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1; sel = s; a = ia; b = ib; cin = ic;
        if (push) begin
            vid++;
            e.id = vid; e.r = er; e.hi = ehi; e.c = ec; e.z = ez;
            q.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check($sformatf("v%0d_result", e.id), 32'(result), 32'(e.r));
                check($sformatf("v%0d_result_hi", e.id), 32'(result_hi), 32'(e.hi));
                check($sformatf("v%0d_c", e.id), 32'(c), 32'(e.c));
                check($sformatf("v%0d_z", e.id), 32'(z), 32'(e.z));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b1; sel = 5'd0; a = 8'hFF; b = 8'h01; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", 32'(result), 32'h0);
        check("rst_result_hi", 32'(result_hi), 32'h0);
        check("rst_c", 32'(c), 32'h0);
        check("rst_z", 32'(z), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;

        //     sel    A      B      cin   R      HI     C     Z
        issue(5'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1); // ADD
        issue(5'd3,  8'h10, 8'h10, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1); // SUBC
        issue(5'd4,  8'h05, 8'h05, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1); // CMP
        issue(5'd11, 8'h81, 8'h00, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 1'b1); // ROL
        issue(5'd13, 8'h80, 8'h00, 1'b0, 8'hC0, 8'h00, 1'b0, 1'b0, 1'b1); // ASR
        issue(5'd1,  8'h7F, 8'h00, 1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1); // ADDC
        issue(5'd2,  8'h03, 8'h05, 1'b0, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b1); // SUB
        issue(5'd5,  8'hF0, 8'h0F, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1); // AND
        issue(5'd6,  8'hA0, 8'h05, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1); // OR
        issue(5'd0,  8'h80, 8'h80, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1); // ADD
        issue(5'd14, 8'h00, 8'h3C, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b1); // MOV
        issue(5'd15, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1); // PASS
        issue(5'd7,  8'h5A, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1); // EXOR
        issue(5'd0,  8'h01, 8'h01, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1); // ADD
        issue(5'd8,  8'h0F, 8'hF0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b1, 1'b1); // TEST
        issue(5'd9,  8'h80, 8'h00, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1); // LSL
        issue(5'd10, 8'h01, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1); // LSR
        issue(5'd12, 8'h01, 8'h00, 1'b0, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1); // ROR
        issue(5'd20, 8'h12, 8'h34, 1'b1, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1); // reserved

`ifdef SEQ_ALU_MUL_EN
        issue(5'd16, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b1); // MUL
        check("mul_busy_k", 32'(busy), 32'h1);
        for (int i = 1; i < W; i++) begin
            if (i == 3) begin
                @(negedge clk);
                start = 1'b1; sel = 5'd0; a = 8'h01; b = 8'h01;
            end
            @(posedge clk);
            #1 start = 1'b0;
            check($sformatf("mul_busy_k%0d", i), 32'(busy), 32'h1);
            check($sformatf("mul_hold_k%0d", i), 32'(result), 32'h80);
        end
        @(posedge clk);
        #1 check("mul_busy_end", 32'(busy), 32'h0);

        // Abort a MUL with reset at its fourth busy edge.
        issue(5'd16, 8'h03, 8'h04, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
`else
        issue(5'd16, 8'hFF, 8'hFF, 1'b0, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1); // MUL as reserved
        check("nomul_busy", 32'(busy), 32'h0);
        check("nomul_hi", 32'(result_hi), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1; sel = 5'd0; a = 8'h11; b = 8'h22;
        @(posedge clk);
        #1;
        check("rst2_result", 32'(result), 32'h0);
        check("rst2_result_hi", 32'(result_hi), 32'h0);
        check("rst2_c", 32'(c), 32'h0);
        check("rst2_z", 32'(z), 32'h0);
        check("rst2_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;

        issue(5'd0,  8'h02, 8'h03, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1); // ADD after reset

        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("drain", 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 CLK  input  1  rising-edge clock, sole clock of the block.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 START  input  1  request; samples SEL/A/B/CIN in the same cycle.
REQ-005 SEL  input  5  opcode (see REQ-011).
REQ-006 A, B  input  WIDTH each  operands.
REQ-007 CIN  input  1  carry/shift-in.
REQ-008 RESULT  output  WIDTH  registered result (low half for MUL).
REQ-009 RESULT_HI  output  WIDTH  registered high half of MUL product; 0 after every other result-writing op.
REQ-010 C, Z  output  1 each  registered carry and zero flags; BUSY output 1, multi-cycle op in progress; DONE output 1, one-cycle completion pulse.

Function
REQ-011 The opcodes SHALL be: 0 ADD; 1 ADDC (+CIN); 2 SUB; 3 SUBC (-CIN); 4 CMP; 5 AND; 6 OR; 7 EXOR; 8 TEST; 9 LSL {C,R}={A,CIN}; 10 LSR C=A[0], R={CIN,A[W-1:1]}; 11 ROL C=A[W-1], R={A[W-2:0],A[W-1]}; 12 ROR C=A[0], R={A[0],A[W-1:1]}; 13 ASR C=A[0], R={A[W-1],A[W-1:1]}; 14 MOV R=B; 15 PASS R=A; 16 MUL unsigned; 17-31 reserved.
REQ-012 Arithmetic SHALL use WIDTH+1-bit sums; ADD/ADDC C = carry-out; SUB/SUBC/CMP C = borrow (1 when A < B (+CIN)).
REQ-013 CMP and TEST SHALL update C and Z only; RESULT and RESULT_HI hold.
REQ-014 AND/OR/EXOR/TEST SHALL clear C; MOV and PASS SHALL leave C unchanged.
REQ-015 Z SHALL be 1 iff the written (or, for CMP/TEST, computed) WIDTH-bit result is zero; for MUL iff the full 2*WIDTH product is zero.
REQ-016 FSM states: IDLE, MUL; START is accepted only in IDLE and ignored while BUSY=1.
REQ-017 Single-cycle ops (0-15) accepted at edge k SHALL update outputs at edge k and assert DONE for the cycle after edge k; FSM stays IDLE, so back-to-back STARTs complete one per cycle.
REQ-018 MUL accepted at edge k SHALL latch A and B, enter MUL, hold BUSY=1 from edge k through edge k+WIDTH, perform one shift-add iteration per edge k+1..k+WIDTH, write {RESULT_HI,RESULT}=A*B at edge k+WIDTH, pulse DONE and return to IDLE.
REQ-019 MUL C SHALL be 1 iff RESULT_HI is nonzero.
REQ-020 RESULT, RESULT_HI, C and Z SHALL hold their previous values while BUSY=1; input changes during BUSY have no effect.
REQ-021 Reserved opcodes SHALL change no output except a DONE pulse, with single-cycle timing.
REQ-022 DONE SHALL never be high for two consecutive cycles from one operation.

Reset
REQ-023 RST_N=0 at a rising edge SHALL set RESULT=0, RESULT_HI=0, C=0, Z=0, BUSY=0, DONE=0, iteration counter=0 and FSM=IDLE.
REQ-024 Reset during MUL SHALL abort it with no DONE and no result write.
REQ-025 START coincident with RST_N=0 SHALL be ignored.

Configuration
REQ-026 Macro SEQ_ALU_MUL_EN defined: MUL datapath, RESULT_HI register and MUL state are compiled in per REQ-018/019.
REQ-027 SEQ_ALU_MUL_EN undefined: opcode 16 is treated as reserved (REQ-021), RESULT_HI is tied to 0 and BUSY is constant 0.

Verification
REQ-028 WIDTH=8: ADD A=0xFF B=0x01 -> RESULT=0x00, C=1, Z=1, DONE one cycle later.
REQ-029 WIDTH=8: SUBC A=0x10 B=0x10 CIN=1 -> RESULT=0xFF, C=1, Z=0; then CMP A=0x05 B=0x05 -> C=0, Z=1, RESULT stays 0xFF.
REQ-030 WIDTH=8, SEQ_ALU_MUL_EN: MUL A=0xFF B=0xFF -> BUSY high 8 edges, then RESULT_HI=0xFE, RESULT=0x01, C=1, Z=0, single DONE; START pulsed mid-operation is ignored.
REQ-031 WIDTH=8: ROL A=0x81 -> RESULT=0x03, C=1; ASR A=0x80 -> RESULT=0xC0, C=0; back-to-back STARTs give DONE on two consecutive cycles.
REQ-032 MUL started, RST_N=0 at 4th busy edge -> all outputs 0, no DONE; next ADD A=0x02 B=0x03 -> RESULT=0x05; SEQ_ALU_MUL_EN undefined: MUL -> outputs unchanged, DONE pulses, BUSY=0.
